// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: 8-bit / 4-bit unsigned restoring divider,
// one quotient bit per clock. Optional DIV_SELFCHECK_EN adds a result check.
module seq_restoring_divider (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [7:0] quotient,
  output logic [3:0] remainder,
  output logic       div_by_zero,
  output logic       check_err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state;
  logic [7:0] d_q;
  logic [7:0] q_q;
  logic [3:0] v_q;
  logic [4:0] r_q;
  logic [2:0] cnt_q;

  logic [4:0] r_sh;
  logic [4:0] r_nx;
  logic [7:0] q_nx;
  logic       q_bit;
  logic       accept;
  logic       complete;

  // One restoring step plus the accept/complete strobes
  always_comb begin
    r_sh     = {r_q[3:0], d_q[7]};
    q_bit    = (r_sh >= {1'b0, v_q});
    r_nx     = q_bit ? (r_sh - {1'b0, v_q}) : r_sh;
    q_nx     = {q_q[6:0], q_bit};
    accept   = start && (state != RUN);
    complete = (state == RUN) &&
               ((v_q == 4'd0) || (cnt_q == 3'd7));
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      d_q         <= 8'h00;
      q_q         <= 8'h00;
      v_q         <= 4'h0;
      r_q         <= 5'h00;
      cnt_q       <= 3'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= 8'h00;
      remainder   <= 4'h0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (accept) begin
            d_q   <= dividend;
            v_q   <= divisor;
            r_q   <= 5'h00;
            q_q   <= 8'h00;
            cnt_q <= 3'd0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (v_q == 4'd0) begin
            // zero divisor: skip the iterations, report saturated result
            quotient    <= 8'hFF;
            remainder   <= 4'h0;
            div_by_zero <= 1'b1;
          end else begin
            d_q   <= {d_q[6:0], 1'b0};
            r_q   <= r_nx;
            q_q   <= q_nx;
            cnt_q <= cnt_q + 3'd1;
            if (complete) begin
              quotient    <= q_nx;
              remainder   <= r_nx[3:0];
              div_by_zero <= 1'b0;
            end
          end
          if (complete) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DIV_SELFCHECK_EN
  logic [7:0]  a_q;
  logic [11:0] chk_sum;
  logic        chk_bad;

  // Recombine the result being written and compare to the operand
  always_comb begin
    chk_sum = ({4'h0, q_nx} * {8'h00, v_q}) + {8'h00, r_nx[3:0]};
    chk_bad = (chk_sum != {4'h0, a_q});
  end

  // Keep the original dividend and register the check on completion
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= 8'h00;
      check_err <= 1'b0;
    end else begin
      if (accept) a_q <= dividend;
      if (complete) check_err <= (v_q == 4'd0) ? 1'b0 : chk_bad;
    end
  end
`else
  assign check_err = 1'b0;
`endif

endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: directed steps with an expected-result queue.
// Ends with a full operand sweep against a behavioural model.
module tb_seq_restoring_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;
  logic       check_err;

  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    logic       dz;
    int         lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  seq_restoring_divider dut (
    .clk(clk), .rst(rst), .start(start),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .check_err(check_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] a, input logic [3:0] b);
    exp_t e;
    if (b == 4'd0) begin
      e.q = 8'hFF; e.r = 4'h0; e.dz = 1'b1; e.lat = 1;
    end else begin
      e.q = a / b; e.r = a % b; e.dz = 1'b0; e.lat = 8;
    end
    exp_q.push_back(e);
  endtask

  // Count cycles to done, then compare against the queue head
  task automatic wait_check(input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    if (exp_q.size() == 0) begin
      chk({tag, "_queue"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_lat"}, n, e.lat);
      chk({tag, "_q"}, quotient, e.q);
      chk({tag, "_r"}, remainder, e.r);
      chk({tag, "_dz"}, div_by_zero, e.dz);
      chk({tag, "_cerr"}, check_err, 0);
      chk({tag, "_busy"}, busy, 0);
    end
  endtask

  task automatic run_op(input string tag,
                        input logic [7:0] a,
                        input logic [3:0] b);
    start = 1'b1; dividend = a; divisor = b;
    push_exp(a, b);
    tick();
    start = 1'b0;
    chk({tag, "_busy0"}, busy, 1);
    wait_check(tag);
    tick();
    chk({tag, "_pulse"}, done, 0);
  endtask

  initial begin
    int   n;
    logic seen;
    rst = 1'b1; start = 1'b0; dividend = 8'h00; divisor = 4'h0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_dz", div_by_zero, 0);
    chk("rst_cerr", check_err, 0);
    rst = 1'b0;
    tick();

    run_op("d200_7", 8'd200, 4'd7);
    run_op("d255_1", 8'd255, 4'd1);
    run_op("d5_9", 8'd5, 4'd9);
    run_op("d0_15", 8'd0, 4'd15);
    run_op("d100_0", 8'd100, 4'd0);
    run_op("d100_10", 8'd100, 4'd10);

    // start while busy is ignored; held start chains back-to-back
    start = 1'b1; dividend = 8'd77; divisor = 4'd3;
    push_exp(8'd77, 4'd3);
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1; dividend = 8'd10; divisor = 4'd2;
    push_exp(8'd10, 4'd2);
    tick();
    chk("ign_busy", busy, 1);
    chk("ign_hold_q", quotient, 10);
    n = 3;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    chk("ign_lat", n, 8);
    begin
      exp_t e;
      e = exp_q.pop_front();
      chk("ign_q", quotient, e.q);
      chk("ign_r", remainder, e.r);
    end
    tick();
    start = 1'b0;
    chk("b2b_busy", busy, 1);
    chk("b2b_done", done, 0);
    wait_check("b2b");
    tick();

    // reset mid-operation aborts without a done pulse
    start = 1'b1; dividend = 8'd200; divisor = 4'd7;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_q", quotient, 0);
    chk("abort_r", remainder, 0);
    chk("abort_dz", div_by_zero, 0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done) seen = 1'b1;
      tick();
    end
    chk("abort_nodone", seen, 0);
    run_op("d9_4", 8'd9, 4'd4);

    // reset and start together: reset wins
    rst = 1'b1; start = 1'b1; dividend = 8'd50; divisor = 4'd5;
    tick();
    rst = 1'b0; start = 1'b0;
    chk("rst_start_busy", busy, 0);
    tick();
    chk("rst_start_idle", busy, 0);

    // every operand pair
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op("sweep", a[7:0], b[3:0]);
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
